dpram_w1r2_scheduler: RTL and testbench

- Controller in front of the single-width-write / double-width-read dual-port RAM (the RAM's write and read ports both run on the one clk).
- Shares the RAM write port between two requesters (req0 = ROM/ioctl loader, req1 = CPU) using round-robin arbitration.
- Sequences burst reads on the double-width read port: steps the address by 2 and produces an aligned valid/done stream.
- Sits between the loader/CPU bus and the video/line-buffer fetch logic.

---
 rtl/dpram_w1r2_scheduler_pkg.sv | 15 +
 rtl/dpram_w1r2_wr_arb.sv | 77 +++++++
 rtl/dpram_w1r2_scheduler.sv | 120 ++++++++++++
 tb/tb_dpram_w1r2_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_w1r2_scheduler_pkg.sv
// Shared types and constants for the W1R2 dual-port RAM scheduler.
package dpram_w1r2_scheduler_pkg;

  // Burst read sequencer states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } rd_state_e;

  // Write requester indices.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/dpram_w1r2_wr_arb.sv
// Two-requester round-robin arbiter for the RAM write port; all outputs registered.
module dpram_w1r2_wr_arb
  import dpram_w1r2_scheduler_pkg::*;
#(
  parameter int unsigned address_width = 10,
  parameter int unsigned data_width    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_wr,
  input  logic [address_width-1:0] req0_addr,
  input  logic [data_width-1:0]    req0_data,
  output logic                     req0_ack,
  input  logic                     req1_wr,
  input  logic [address_width-1:0] req1_addr,
  input  logic [data_width-1:0]    req1_data,
  output logic                     req1_ack,
  output logic                     ram_wren,
  output logic [address_width-1:0] ram_wr_addr,
  output logic [data_width-1:0]    ram_wr_data
);

  logic                     wren_q;
  logic                     ack0_q;
  logic                     ack1_q;
  logic [address_width-1:0] addr_q;
  logic [data_width-1:0]    data_q;
  logic                     last_q;

  logic elig0;
  logic elig1;
  logic grant;
  logic pick;

  // A requester acked this cycle is ineligible so a held request is written once.
  assign elig0 = req0_wr & ~ack0_q;
  assign elig1 = req1_wr & ~ack1_q;

  // Choose the winner; on a tie the requester not granted last wins.
  always_comb begin
    grant = elig0 | elig1;
    pick  = REQ0;
    if (elig0 && elig1) begin
      pick = (last_q == REQ0) ? REQ1 : REQ0;
    end else if (elig1) begin
      pick = REQ1;
    end
  end

  // Register the grant, write command and round-robin history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wren_q <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      last_q <= REQ1;
    end else begin
      wren_q <= grant;
      ack0_q <= grant && (pick == REQ0);
      ack1_q <= grant && (pick == REQ1);
      if (grant) begin
        addr_q <= (pick == REQ1) ? req1_addr : req0_addr;
        data_q <= (pick == REQ1) ? req1_data : req0_data;
        last_q <= pick;
      end
    end
  end

  assign ram_wren    = wren_q;
  assign req0_ack    = ack0_q;
  assign req1_ack    = ack1_q;
  assign ram_wr_addr = addr_q;
  assign ram_wr_data = data_q;

endmodule

// File: rtl/dpram_w1r2_scheduler.sv
// Front-end for a single-width-write / double-width-read RAM: write arbitration
// plus a burst read sequencer stepping the read address by two.
module dpram_w1r2_scheduler
  import dpram_w1r2_scheduler_pkg::*;
#(
  parameter int unsigned address_width = 10,
  parameter int unsigned data_width    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req0_wr,
  input  logic [address_width-1:0]   req0_addr,
  input  logic [data_width-1:0]      req0_data,
  output logic                       req0_ack,
  input  logic                       req1_wr,
  input  logic [address_width-1:0]   req1_addr,
  input  logic [data_width-1:0]      req1_data,
  output logic                       req1_ack,
  output logic                       ram_wren,
  output logic [address_width-1:0]   ram_wr_addr,
  output logic [data_width-1:0]      ram_wr_data,
  input  logic                       rd_start,
  input  logic [address_width-1:0]   rd_addr,
  input  logic [address_width-1:0]   rd_count,
  output logic                       rd_busy,
  output logic [address_width-1:0]   ram_rd_addr,
  input  logic [2*data_width-1:0]    ram_q,
  output logic [2*data_width-1:0]    rd_data,
  output logic                       rd_valid,
  output logic                       rd_done
);

  localparam logic [address_width-1:0] AddrOne  = address_width'(1);
  localparam logic [address_width-1:0] AddrStep = address_width'(2);

  dpram_w1r2_wr_arb #(
    .address_width(address_width),
    .data_width   (data_width)
  ) u_wr_arb (
    .clk        (clk),
    .reset      (reset),
    .req0_wr    (req0_wr),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ack   (req0_ack),
    .req1_wr    (req1_wr),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ack   (req1_ack),
    .ram_wren   (ram_wren),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data)
  );

  rd_state_e                state_q, state_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [address_width-1:0] remaining_q, remaining_d;
  logic                     valid_q;
  logic                     done_q;
  logic                     issue;
  logic                     last;

  // Sequencer next state; issue marks a RAM read launched this cycle.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    issue       = 1'b0;
    last        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_start && (rd_count != '0)) begin
          addr_d      = rd_addr;
          remaining_d = rd_count - AddrOne;
          state_d     = StRun;
        end
      end
      StRun: begin
        issue = 1'b1;
        if (remaining_q == '0) begin
          last    = 1'b1;
          state_d = StDrain;
        end else begin
          addr_d      = addr_q + AddrStep;
          remaining_d = remaining_q - AddrOne;
        end
      end
      StDrain: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state plus the one-cycle valid/done delay matching RAM latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      valid_q     <= issue;
      done_q      <= last;
    end
  end

  assign rd_busy     = (state_q != StIdle);
  assign ram_rd_addr = addr_q;
  assign rd_data     = ram_q;
  assign rd_valid    = valid_q;
  assign rd_done     = done_q;

endmodule

// File: tb/tb_dpram_w1r2_scheduler.sv
// Self-checking bench for dpram_w1r2_scheduler with a behavioural RAM model.
module tb_dpram_w1r2_scheduler;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_wr, req1_wr, req0_ack, req1_ack;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          ram_wren;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic          rd_start, rd_busy, rd_valid, rd_done;
  logic [AW-1:0] rd_addr, rd_count, ram_rd_addr;
  logic [2*DW-1:0] ram_q, rd_data;

  always #5 clk = ~clk;

  dpram_w1r2_scheduler #(
    .address_width(AW),
    .data_width   (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_wr    (req0_wr),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ack   (req0_ack),
    .req1_wr    (req1_wr),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ack   (req1_ack),
    .ram_wren   (ram_wren),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .rd_start   (rd_start),
    .rd_addr    (rd_addr),
    .rd_count   (rd_count),
    .rd_busy    (rd_busy),
    .ram_rd_addr(ram_rd_addr),
    .ram_q      (ram_q),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_done    (rd_done)
  );

  // Read-port model: registered pair {mem[a], mem[a+1]}, +1 truncating.
  logic [DW-1:0] mem [1<<AW];
  logic [AW-1:0] rd_nxt;
  assign rd_nxt = ram_rd_addr + 10'd1;
  always @(posedge clk) ram_q <= {mem[ram_rd_addr], mem[rd_nxt]};

  typedef struct packed {
    logic          src;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [AW-1:0]   count;
    logic            poke;
    logic [2*DW-1:0] exp_first;
    logic [2*DW-1:0] exp_last;
  } burst_t;

  wr_t             wr_q[$];
  logic [2*DW-1:0] rd_q[$];
  wr_t             mon_w;
  logic [2*DW-1:0] mon_r;
  burst_t          tbl[5];
  int              checks = 0;
  int              errors = 0;
  int              wren_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_wren) begin
        wren_cnt++;
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got write addr %0h data %0h expected none",
                   ram_wr_addr, ram_wr_data);
        end else begin
          mon_w = wr_q.pop_front();
          chk("wr_addr", 32'(ram_wr_addr), 32'(mon_w.addr));
          chk("wr_data", 32'(ram_wr_data), 32'(mon_w.data));
          chk("wr_ack0", 32'(req0_ack), 32'(mon_w.src == 1'b0));
          chk("wr_ack1", 32'(req1_ack), 32'(mon_w.src == 1'b1));
        end
      end else begin
        chk("ack_without_wren", 32'({req0_ack, req1_ack}), 32'd0);
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got data %0h expected no valid", rd_data);
        end else begin
          mon_r = rd_q.pop_front();
          chk("rd_data_sb", 32'(rd_data), 32'(mon_r));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Start a burst in the current cycle and check its cycle-exact timing.
  task automatic run_burst(input burst_t e);
    logic [AW-1:0] a;
    logic [AW-1:0] a1;
    int            cnt;
    cnt = int'(e.count);
    chk("idle_busy", 32'(rd_busy), 32'd0);
    rd_start = 1'b1;
    rd_addr  = e.addr;
    rd_count = e.count;
    a = e.addr;
    for (int j = 0; j < cnt; j++) begin
      a1 = a + 10'd1;
      rd_q.push_back({mem[a], mem[a1]});
      a = a + 10'd2;
    end
    for (int k = 1; k <= cnt + 1; k++) begin
      cyc();
      if (k == 1) rd_start = 1'b0;
      if (e.poke && k == 2) begin
        rd_start = 1'b1;
        rd_addr  = 10'd0;
        rd_count = 10'd5;
      end
      if (e.poke && k == 3) rd_start = 1'b0;
      chk("burst_busy", 32'(rd_busy), 32'd1);
      chk("burst_valid", 32'(rd_valid), 32'(k >= 2));
      chk("burst_done", 32'(rd_done), 32'(k == cnt + 1));
      if (k == 1) chk("burst_addr0", 32'(ram_rd_addr), 32'(e.addr));
      if (k == 2 && cnt > 1) begin
        a1 = e.addr + 10'd2;
        chk("burst_addr1", 32'(ram_rd_addr), 32'(a1));
      end
      if (k == 2) chk("burst_first", 32'(rd_data), 32'(e.exp_first));
      if (k == cnt + 1) chk("burst_last", 32'(rd_data), 32'(e.exp_last));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int n0;
    int n1;
    logic seen;

    tbl[0] = '{addr: 10'd4,    count: 10'd3, poke: 1'b1, exp_first: 16'h0405, exp_last: 16'h0809};
    tbl[1] = '{addr: 10'd1022, count: 10'd2, poke: 1'b0, exp_first: 16'hFEFF, exp_last: 16'h0001};
    tbl[2] = '{addr: 10'd1,    count: 10'd2, poke: 1'b0, exp_first: 16'h0102, exp_last: 16'h0304};
    tbl[3] = '{addr: 10'd1023, count: 10'd1, poke: 1'b0, exp_first: 16'hFF00, exp_last: 16'hFF00};
    tbl[4] = '{addr: 10'd0,    count: 10'd1, poke: 1'b0, exp_first: 16'h0001, exp_last: 16'h0001};
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i);

    reset = 1'b1;
    req0_wr = 1'b0; req0_addr = '0; req0_data = '0;
    req1_wr = 1'b0; req1_addr = '0; req1_data = '0;
    rd_start = 1'b0; rd_addr = '0; rd_count = '0;
    repeat (3) cyc();
    chk("rst_wren", 32'(ram_wren), 32'd0);
    chk("rst_acks", 32'({req0_ack, req1_ack}), 32'd0);
    chk("rst_rd_flags", 32'({rd_busy, rd_valid, rd_done}), 32'd0);
    chk("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(ram_wr_data), 32'd0);
    chk("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
    reset = 1'b0;
    cyc();
    chk("idle_flags", 32'({ram_wren, rd_busy, rd_valid, rd_done}), 32'd0);

    // Both requesters held: req0 wins the first tie, then strict alternation.
    n0 = 0; n1 = 0; acks = 0; wren_cnt = 0;
    req0_wr = 1'b1; req0_addr = 10'h20; req0_data = 8'hA0;
    req1_wr = 1'b1; req1_addr = 10'h30; req1_data = 8'hB0;
    wr_q.push_back('{src: 1'b0, addr: 10'h20, data: 8'hA0});
    wr_q.push_back('{src: 1'b1, addr: 10'h30, data: 8'hB0});
    wr_q.push_back('{src: 1'b0, addr: 10'h21, data: 8'hA1});
    wr_q.push_back('{src: 1'b1, addr: 10'h31, data: 8'hB1});
    for (int k = 0; k < 20 && acks < 4; k++) begin
      cyc();
      chk("both_wren", 32'(ram_wren), 32'd1);
      if (req0_ack) begin
        acks++; n0++;
        req0_addr = 10'h20 + 10'(n0);
        req0_data = 8'hA0 + 8'(n0);
      end
      if (req1_ack) begin
        acks++; n1++;
        req1_addr = 10'h30 + 10'(n1);
        req1_data = 8'hB0 + 8'(n1);
      end
      if (acks >= 4) begin
        req0_wr = 1'b0;
        req1_wr = 1'b0;
      end
    end
    chk("both_acks", 32'(acks), 32'd4);
    req0_wr = 1'b0; req1_wr = 1'b0;
    repeat (3) cyc();
    chk("both_wren_cnt", 32'(wren_cnt), 32'd4);
    chk("both_wrq_empty", 32'(wr_q.size()), 32'd0);

    // req0 alone, held until its ack.
    wren_cnt = 0; seen = 1'b0;
    req0_wr = 1'b1; req0_addr = 10'd5; req0_data = 8'h10;
    wr_q.push_back('{src: 1'b0, addr: 10'd5, data: 8'h10});
    for (int k = 0; k < 10 && !seen; k++) begin
      cyc();
      if (req0_ack) begin
        req0_wr = 1'b0;
        seen = 1'b1;
      end
    end
    chk("single_ack_seen", 32'(seen), 32'd1);
    req0_wr = 1'b0;
    repeat (3) cyc();
    chk("single_wren_cnt", 32'(wren_cnt), 32'd1);
    chk("single_wrq_empty", 32'(wr_q.size()), 32'd0);

    // Table of bursts, each started in the cycle after the previous rd_done.
    for (int i = 0; i < 5; i++) begin
      cyc();
      run_burst(tbl[i]);
    end

    // Zero-length start is ignored.
    cyc();
    rd_start = 1'b1; rd_addr = 10'd7; rd_count = 10'd0;
    cyc();
    rd_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("zero_busy", 32'(rd_busy), 32'd0);
      chk("zero_valid", 32'(rd_valid), 32'd0);
    end

    // Reset in the middle of a burst and of a pending write.
    rd_start = 1'b1; rd_addr = 10'd8; rd_count = 10'd4;
    for (int j = 0; j < 4; j++) rd_q.push_back({mem[8 + 2 * j], mem[9 + 2 * j]});
    cyc();
    rd_start = 1'b0;
    cyc();
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    req1_wr = 1'b1; req1_addr = 10'd9; req1_data = 8'h55;
    reset = 1'b1;
    #1;
    chk("mid_rst_flags", 32'({rd_busy, rd_valid, rd_done}), 32'd0);
    rd_q.delete();
    cyc();
    req1_wr = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("post_rst_wren", 32'(ram_wren), 32'd0);
    end
    run_burst(tbl[4]);

    repeat (3) cyc();
    chk("end_rdq_empty", 32'(rd_q.size()), 32'd0);
    chk("end_wrq_empty", 32'(wr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
